// File: rtl/wb_stream_fifo_slave_pkg.sv
// Shared register-map constants and the STATUS word layout for the
// Wishbone-to-stream FIFO slave.
package wbfs_pkg;

    typedef logic [1:0] wbfs_off_t;

    localparam wbfs_off_t OFF_DATA   = 2'd0;
    localparam wbfs_off_t OFF_STATUS = 2'd1;
    localparam wbfs_off_t OFF_CTRL   = 2'd2;

    localparam int ST_LEVEL_LSB = 0;
    localparam int ST_EMPTY     = 8;
    localparam int ST_FULL      = 9;
    localparam int ST_ERR       = 10;
    localparam int ST_PCNT_LSB  = 32;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_ERR = 1;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_ACK,
        RESP_ERR
    } wbfs_resp_t;

    function automatic logic [63:0] status_word(
        input logic [7:0]  level,
        input logic        empty,
        input logic        full,
        input logic        err_sticky,
        input logic [31:0] push_count
    );
        logic [63:0] w_s;
        w_s = '0;
        w_s[ST_LEVEL_LSB +: 8] = level;
        w_s[ST_EMPTY]          = empty;
        w_s[ST_FULL]           = full;
        w_s[ST_ERR]            = err_sticky;
        w_s[ST_PCNT_LSB +: 32] = push_count;
        return w_s;
    endfunction

endpackage

// File: rtl/wb_stream_fifo_slave_if.sv
// Wishbone classic bus bundle between the bridge (master) and the FIFO slave.
interface wb_stream_fifo_slave_if #(
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int TW = 2
);
    logic [AW-1:0]   wb_adr;
    logic [DW-1:0]   wb_dat_i;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel;
    logic            wb_we;
    logic            wb_cyc;
    logic            wb_stb;
    logic            wb_ack;
    logic            wb_err;
    logic            wb_rty;
    logic [TW-1:0]   wb_tgd_o;

    modport master (
        output wb_adr, wb_dat_i, wb_sel, wb_we, wb_cyc, wb_stb,
        input  wb_dat_o, wb_ack, wb_err, wb_rty, wb_tgd_o
    );

    modport slave (
        input  wb_adr, wb_dat_i, wb_sel, wb_we, wb_cyc, wb_stb,
        output wb_dat_o, wb_ack, wb_err, wb_rty, wb_tgd_o
    );
endinterface

// File: rtl/wb_stream_fifo_slave_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module wbfs_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_valid,
    output logic [DW-1:0]            o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic [PW:0]   w_level;
    logic          w_do_pop;

    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign o_level  = w_level;
    assign o_empty  = (w_level == '0);
    assign o_full   = (w_level == (PW+1)'(DEPTH));
    assign o_valid  = !o_empty;
    assign w_do_pop = i_pop && !o_empty;

    // Head word is gated so the stream data reads as zero whenever nothing is valid.
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_stream_fifo_slave.sv
// Wishbone classic slave: DATA writes feed a FIFO that drains to a
// valid/ready stream; STATUS/CONTROL registers share the bus.
module wb_stream_fifo_slave
    import wbfs_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int TW    = 2,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wb_stream_fifo_slave_if.slave  wb,
    output logic                   m_valid,
    output logic [DW-1:0]          m_data,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] fifo_level
);
    logic          r_ack;
    logic          r_err;
    logic [DW-1:0] r_dat;
    logic          r_err_sticky;
    logic [31:0]   r_push_count;

    wbfs_resp_t    w_resp;
    logic [DW-1:0] w_dat;
    logic          w_push;
    logic          w_flush;
    logic          w_clr_err;
    logic          w_req;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    wbfs_off_t     w_off;
    logic [DW-1:0] w_status;
    logic          w_unused;

    assign w_req    = wb.wb_cyc && wb.wb_stb && !r_ack && !r_err;
    assign w_off    = wb.wb_adr[4:3];
    assign w_pop    = m_valid && m_ready;
    assign w_status = status_word(8'(fifo_level), w_empty, w_full, r_err_sticky, r_push_count);
    assign w_unused = ^{wb.wb_adr[AW-1:5], wb.wb_adr[2:0]};

    always_comb begin
        w_resp    = RESP_NONE;
        w_dat     = '0;
        w_push    = 1'b0;
        w_flush   = 1'b0;
        w_clr_err = 1'b0;
        if (w_req) begin
            case (w_off)
                OFF_DATA: begin
                    if (!wb.wb_we) begin
                        w_resp = RESP_ACK;
                    end else if (!(&wb.wb_sel)) begin
                        w_resp = RESP_ERR;
                    end else if (!w_full || w_pop) begin
                        // A pop in this cycle frees the slot the push lands in.
                        w_resp = RESP_ACK;
                        w_push = 1'b1;
                    end
                end
                OFF_STATUS: begin
                    if (wb.wb_we) begin
                        w_resp = RESP_ERR;
                    end else begin
                        w_resp = RESP_ACK;
                        w_dat  = w_status;
                    end
                end
                OFF_CTRL: begin
                    w_resp = RESP_ACK;
                    if (wb.wb_we) begin
                        w_flush   = wb.wb_dat_i[CTRL_FLUSH];
                        w_clr_err = wb.wb_dat_i[CTRL_CLR_ERR];
                    end
                end
                default: w_resp = RESP_ERR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_dat        <= '0;
            r_err_sticky <= 1'b0;
            r_push_count <= '0;
        end else begin
            r_ack <= (w_resp == RESP_ACK);
            r_err <= (w_resp == RESP_ERR);
            r_dat <= w_dat;
            if (w_resp == RESP_ERR) begin
                r_err_sticky <= 1'b1;
            end else if (w_clr_err) begin
                r_err_sticky <= 1'b0;
            end
            if (w_push) begin
                r_push_count <= r_push_count + 32'd1;
            end
        end
    end

    wbfs_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (wb.wb_dat_i),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign wb.wb_ack   = r_ack;
    assign wb.wb_err   = r_err;
    assign wb.wb_dat_o = r_dat;
    assign wb.wb_rty   = 1'b0;
    assign wb.wb_tgd_o = '0;

endmodule
